mem_access_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the execute stage's EX/MEM latch.
- Resolves branches (PCSrc), performs data-memory loads and stores with a configurable number of wait states, and registers results into the MEM/WB latch for write-back.
- Asserts a stall toward upstream stages while a multi-cycle access is in progress.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/data_memory.sv | 19 +
 rtl/mem_access_stage.sv | 113 +++++++++++
 tb/tb_mem_access_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: WB/M control bit positions and MEM-stage FSM encoding.
package pipeline_pkg;
   localparam int unsigned WB_W        = 2;
   localparam int unsigned WB_REGWRITE = 1;
   localparam int unsigned WB_MEMTOREG = 0;

   localparam int unsigned M_BRANCH    = 2;
   localparam int unsigned M_MEMREAD   = 1;
   localparam int unsigned M_MEMWRITE  = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_t;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write. Not cleared by reset.
module data_memory #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: branch resolve, multi-cycle data-memory access, MEM/WB latch.
// Optional MEM_ALIGN_CHECK_EN adds a misaligned flag and suppresses misaligned writes/loads.
module mem_access_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned MEM_LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wb_ctl,
   input  logic        branch,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        zero,
   input  logic [31:0] branch_addr,
   input  logic [31:0] alu_result,
   input  logic [31:0] rdata2,
   input  logic [4:0]  write_reg,
   output logic        pcsrc,
   output logic [31:0] pc_target,
   output logic        mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        misaligned,
`endif
   output logic [1:0]  wb_ctlout,
   output logic [31:0] read_data,
   output logic [31:0] mem_alu_result,
   output logic [4:0]  mem_write_reg
);
   localparam int unsigned CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

   logic        access;
   logic        complete;
   logic        misalign;
   logic        do_write;
   logic        bubble_load;
   logic [31:0] mem_rdata;
   logic        unused_addr_bits;

   assign access    = memread | memwrite;
   assign pcsrc     = branch & zero;
   assign pc_target = branch_addr;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign   = access & (alu_result[1:0] != 2'b00);
   assign misaligned = misalign;
`else
   assign misalign   = 1'b0;
`endif

   assign unused_addr_bits = ^{alu_result[31:ADDR_W+2], alu_result[1:0]};

   // Stall sequencing: IDLE takes the first stall cycle, WAIT counts the rest.
   if (MEM_LATENCY == 0) begin : g_no_wait
      assign mem_stall = 1'b0;
   end else begin : g_wait
      mem_state_t       state;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
         if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: if (access) begin
                  state <= S_WAIT;
                  cnt   <= CNT_W'(MEM_LATENCY - 1);
               end
               S_WAIT: if (cnt == '0) state <= S_IDLE;
                       else           cnt   <= cnt - CNT_W'(1);
               default: state <= S_IDLE;
            endcase
         end
      end

      assign mem_stall = (state == S_IDLE) ? access : (cnt != '0);
   end

   assign complete    = ~mem_stall;
   assign do_write    = memwrite & complete & ~misalign & ~rst;
   assign bubble_load = memread & misalign;

   data_memory #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .we    (do_write),
      .addr  (alu_result[ADDR_W+1:2]),
      .wdata (rdata2),
      .rdata (mem_rdata)
   );

   // MEM/WB latch: bubble while stalled, capture on the completing cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_ctlout      <= '0;
         read_data      <= '0;
         mem_alu_result <= '0;
         mem_write_reg  <= '0;
      end else if (complete) begin
         wb_ctlout      <= bubble_load ? '0 : wb_ctl;
         read_data      <= mem_rdata;
         mem_alu_result <= alu_result;
         mem_write_reg  <= write_reg;
      end else begin
         wb_ctlout      <= '0;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: three instances (latency 0, 2, 3) share the input bus.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst0, rst2, rst3;
   logic [1:0]  wb_ctl;
   logic        branch, memread, memwrite, zero;
   logic [31:0] branch_addr, alu_result, rdata2;
   logic [4:0]  write_reg;

   logic        pcsrc0, pcsrc2, pcsrc3;
   logic [31:0] pct0, pct2, pct3;
   logic        stall0, stall2, stall3;
   logic [1:0]  wbo0, wbo2, wbo3;
   logic [31:0] rd0, rd2, rd3;
   logic [31:0] alu0, alu2, alu3;
   logic [4:0]  wr0, wr2, wr3;
`ifdef MEM_ALIGN_CHECK_EN
   logic        mis0, mis2, mis3;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(0)) u_lat0 (
      .clk(clk), .rst(rst0), .wb_ctl(wb_ctl), .branch(branch), .memread(memread),
      .memwrite(memwrite), .zero(zero), .branch_addr(branch_addr), .alu_result(alu_result),
      .rdata2(rdata2), .write_reg(write_reg), .pcsrc(pcsrc0), .pc_target(pct0),
      .mem_stall(stall0),
`ifdef MEM_ALIGN_CHECK_EN
      .misaligned(mis0),
`endif
      .wb_ctlout(wbo0), .read_data(rd0), .mem_alu_result(alu0), .mem_write_reg(wr0));

   mem_access_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst2), .wb_ctl(wb_ctl), .branch(branch), .memread(memread),
      .memwrite(memwrite), .zero(zero), .branch_addr(branch_addr), .alu_result(alu_result),
      .rdata2(rdata2), .write_reg(write_reg), .pcsrc(pcsrc2), .pc_target(pct2),
      .mem_stall(stall2),
`ifdef MEM_ALIGN_CHECK_EN
      .misaligned(mis2),
`endif
      .wb_ctlout(wbo2), .read_data(rd2), .mem_alu_result(alu2), .mem_write_reg(wr2));

   mem_access_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LATENCY(3)) u_lat3 (
      .clk(clk), .rst(rst3), .wb_ctl(wb_ctl), .branch(branch), .memread(memread),
      .memwrite(memwrite), .zero(zero), .branch_addr(branch_addr), .alu_result(alu_result),
      .rdata2(rdata2), .write_reg(write_reg), .pcsrc(pcsrc3), .pc_target(pct3),
      .mem_stall(stall3),
`ifdef MEM_ALIGN_CHECK_EN
      .misaligned(mis3),
`endif
      .wb_ctlout(wbo3), .read_data(rd3), .mem_alu_result(alu3), .mem_write_reg(wr3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] w, input logic br, input logic rd, input logic wr,
                        input logic z, input logic [31:0] ba, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      wb_ctl = w; branch = br; memread = rd; memwrite = wr; zero = z;
      branch_addr = ba; alu_result = a; rdata2 = d; write_reg = r;
   endtask

   task automatic go_idle(input int n);
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick(); tick();
      n_cmp++; if (wbo0 !== 2'b00) begin n_bad++; $display("FAIL reset_wb_ctlout got %b want 00", wbo0); end
      n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL reset_read_data got %h want 0", rd0); end
      n_cmp++; if (alu0 !== 32'h0) begin n_bad++; $display("FAIL reset_alu_result got %h want 0", alu0); end
      n_cmp++; if (wr0 !== 5'd0) begin n_bad++; $display("FAIL reset_write_reg got %0d want 0", wr0); end
      n_cmp++; if (stall2 !== 1'b0) begin n_bad++; $display("FAIL reset_stall_lat2 got %b want 0", stall2); end
      n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL reset_stall_lat3 got %b want 0", stall3); end
      rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      go_idle(2);
   endtask

   task automatic test_latency0();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'hDEADBEEF, 5'd0);
      #1;
      n_cmp++; if (stall0 !== 1'b0) begin n_bad++; $display("FAIL lat0_store_stall got %b want 0", stall0); end
      tick();
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 5'd9);
      #1;
      n_cmp++; if (stall0 !== 1'b0) begin n_bad++; $display("FAIL lat0_load_stall got %b want 0", stall0); end
      tick();
      n_cmp++; if (rd0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lat0_read_data got %h want deadbeef", rd0); end
      n_cmp++; if (wbo0 !== 2'b11) begin n_bad++; $display("FAIL lat0_wb_ctlout got %b want 11", wbo0); end
      n_cmp++; if (wr0 !== 5'd9) begin n_bad++; $display("FAIL lat0_write_reg got %0d want 9", wr0); end
      go_idle(6);
   endtask

   task automatic test_load_latency2();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h12345678, 5'd0);
      repeat (4) tick();
      go_idle(6);
      drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      n_cmp++; if (wbo2 !== 2'b10) begin n_bad++; $display("FAIL lat2_plain_wb_ctlout got %b want 10", wbo2); end
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 5'd3);
      #1;
      n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL lat2_stall_c0 got %b want 1", stall2); end
      tick();
      n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL lat2_stall_c1 got %b want 1", stall2); end
      n_cmp++; if (wbo2 !== 2'b00) begin n_bad++; $display("FAIL lat2_bubble_c1 got %b want 00", wbo2); end
      tick();
      n_cmp++; if (stall2 !== 1'b0) begin n_bad++; $display("FAIL lat2_stall_c2 got %b want 0", stall2); end
      n_cmp++; if (wbo2 !== 2'b00) begin n_bad++; $display("FAIL lat2_bubble_c2 got %b want 00", wbo2); end
      tick();
      n_cmp++; if (rd2 !== 32'h12345678) begin n_bad++; $display("FAIL lat2_read_data got %h want 12345678", rd2); end
      n_cmp++; if (wbo2 !== 2'b11) begin n_bad++; $display("FAIL lat2_wb_ctlout got %b want 11", wbo2); end
      n_cmp++; if (wr2 !== 5'd3) begin n_bad++; $display("FAIL lat2_write_reg got %0d want 3", wr2); end
      go_idle(6);
   endtask

   task automatic test_branch();
      drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 5'd0);
      #1;
      n_cmp++; if (pcsrc0 !== 1'b1) begin n_bad++; $display("FAIL branch_taken got %b want 1", pcsrc0); end
      n_cmp++; if (pct0 !== 32'h40) begin n_bad++; $display("FAIL branch_target got %h want 40", pct0); end
      zero = 1'b0;
      #1;
      n_cmp++; if (pcsrc0 !== 1'b0) begin n_bad++; $display("FAIL branch_not_taken got %b want 0", pcsrc0); end
      drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h20, 32'h0, 5'd0);
      #1;
      n_cmp++; if (pcsrc2 !== 1'b1) begin n_bad++; $display("FAIL branch_during_stall got %b want 1", pcsrc2); end
      n_cmp++; if (stall2 !== 1'b1) begin n_bad++; $display("FAIL branch_stall_lat2 got %b want 1", stall2); end
      go_idle(6);
   endtask

   task automatic test_reset_abort();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h11111111, 5'd0);
      repeat (4) tick();
      go_idle(6);
      drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'h0, 5'd7);
      tick();
      n_cmp++; if (rd3 !== 32'h11111111) begin n_bad++; $display("FAIL abort_pre_read_data got %h want 11111111", rd3); end
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'hAAAA5555, 5'd0);
      tick();
      n_cmp++; if (stall3 !== 1'b1) begin n_bad++; $display("FAIL abort_second_stall got %b want 1", stall3); end
      rst3 = 1'b1;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      rst3 = 1'b0;
      #1;
      n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL abort_stall_drop got %b want 0", stall3); end
      n_cmp++; if (wbo3 !== 2'b00) begin n_bad++; $display("FAIL abort_wb_ctlout got %b want 00", wbo3); end
      n_cmp++; if (rd3 !== 32'h0) begin n_bad++; $display("FAIL abort_read_data got %h want 0", rd3); end
      n_cmp++; if (alu3 !== 32'h0) begin n_bad++; $display("FAIL abort_alu_result got %h want 0", alu3); end
      n_cmp++; if (wr3 !== 5'd0) begin n_bad++; $display("FAIL abort_write_reg got %0d want 0", wr3); end
      tick();
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 32'h0, 5'd4);
      repeat (4) tick();
      n_cmp++; if (rd3 !== 32'h11111111) begin n_bad++; $display("FAIL abort_word_kept got %h want 11111111", rd3); end
      n_cmp++; if (wbo3 !== 2'b11) begin n_bad++; $display("FAIL abort_reload_wb_ctlout got %b want 11", wbo3); end
      go_idle(6);
   endtask

   task automatic test_addr_wrap();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0);
      tick();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h1, 5'd0);
      tick();
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1);
      tick();
      n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL addr_wrap got %h want 1", rd0); end
      go_idle(6);
   endtask

`ifdef MEM_ALIGN_CHECK_EN
   task automatic test_align();
      drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h13, 32'h0, 5'd0);
      #1;
      n_cmp++; if (mis0 !== 1'b1) begin n_bad++; $display("FAIL align_flag_store got %b want 1", mis0); end
      tick();
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 5'd2);
      #1;
      n_cmp++; if (mis0 !== 1'b0) begin n_bad++; $display("FAIL align_flag_aligned got %b want 0", mis0); end
      tick();
      n_cmp++; if (rd0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL align_store_blocked got %h want deadbeef", rd0); end
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h13, 32'h0, 5'd2);
      tick();
      n_cmp++; if (wbo0 !== 2'b00) begin n_bad++; $display("FAIL align_load_bubble got %b want 00", wbo0); end
      go_idle(6);
   endtask
`endif

   initial begin
      test_reset();
      test_latency0();
      test_load_latency2();
      test_branch();
      test_reset_abort();
      test_addr_wrap();
`ifdef MEM_ALIGN_CHECK_EN
      test_align();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
